// File: rtl/pc_ras_unit_pkg.sv
// Shared types for the multi-program PC:
// opcode encodings, PC state, width helper.
package pc_ras_unit_pkg;

  typedef enum logic [4:0] {
    NOP  = 5'd0,
    BA   = 5'd1,
    BL   = 5'd2,
    BG   = 5'd3,
    BE   = 5'd4,
    CALL = 5'd5,
    RET  = 5'd6,
    HALT = 5'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_FAULT
  } pc_state_t;

  // program-id width, never zero
  function automatic int pid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// Decode/ROM-side bundle of the PC unit.
// master = decode side, slave = PC unit.
interface pc_ras_unit_if
  import pc_ras_unit_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int OFF_W    = 15,
  parameter int NUM_PROG = 3
) ();

  localparam int ID_W = pid_w(NUM_PROG);

  logic [ID_W-1:0]  prog_id;
  op_t              op;
  logic             z;
  logic             lt;
  logic [OFF_W-1:0] bamt;
  logic             stall;
  logic [PC_W-1:0]  PC;
  logic [ID_W-1:0]  prog_sel;
  logic             done;
  logic             fault;

  modport master (
    output prog_id, op, z, lt, bamt, stall,
    input  PC, prog_sel, done, fault
  );

  modport slave (
    input  prog_id, op, z, lt, bamt, stall,
    output PC, prog_sel, done, fault
  );

endinterface

// File: rtl/pc_ras_unit_ras.sv
// Return-address LIFO with synchronous clear.
// Push when full / pop when empty are ignored.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0] sp_q, sp_d;
  logic [W-1:0]    mem_q [2**SP_W];
  logic            do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign top_o   = mem_q[sp_q - SP_W'(1)];

  // next stack pointer
  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + SP_W'(1);
    else if (do_pop) sp_d = sp_q - SP_W'(1);
  end

  // pointer register, cleared on reset
  always_ff @(posedge clk) begin
    if (clr_i) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // entry write on accepted push only
  always_ff @(posedge clk) begin
    if (!clr_i && do_push) mem_q[sp_q] <= din_i;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Multi-program PC with branch resolve,
// CALL/RET through a RAS, HALT and fault states.
module pc_ras_unit
  import pc_ras_unit_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int OFF_W     = 15,
  parameter int NUM_PROG  = 3,
  parameter logic [NUM_PROG*PC_W-1:0] START =
    {8'd48, 8'd28, 8'd0},
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  pc_ras_unit_if.slave bus
);

  localparam int ID_W = pid_w(NUM_PROG);

  pc_state_t       st_q, st_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [ID_W-1:0] sel_q;
  logic [ID_W-1:0] sel_id;
  logic [PC_W-1:0] start_pc;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_tgt;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;
  logic            push, pop;

  assign sel_id   = (int'(bus.prog_id) < NUM_PROG)
                  ? bus.prog_id : '0;
  assign start_pc = START[sel_id*PC_W +: PC_W];
  assign off      = PC_W'($signed(bus.bamt));
  assign pc_inc   = pc_q + PC_W'(1);
  assign pc_tgt   = pc_q + off;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (clk),
    .clr_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .top_o   (ras_top),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  // flag decode, next-PC mux and RAS control
  always_comb begin
    pc_d = pc_q;
    st_d = st_q;
    push = 1'b0;
    pop  = 1'b0;
    if (st_q == ST_RUN && !bus.stall && !reset) begin
      unique case (bus.op)
        BA: pc_d = pc_tgt;
        BL: pc_d = bus.lt ? pc_tgt : pc_inc;
        BG: pc_d = (!bus.lt && !bus.z)
                 ? pc_tgt : pc_inc;
        BE: pc_d = bus.z ? pc_tgt : pc_inc;
        CALL: begin
          if (ras_full) st_d = ST_FAULT;
          else begin
            push = 1'b1;
            pc_d = pc_tgt;
          end
        end
        RET: begin
          if (ras_empty) st_d = ST_FAULT;
          else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        HALT: st_d = ST_HALTED;
        default: pc_d = pc_inc;
      endcase
    end
  end

  // state, PC and program-select registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= start_pc;
      sel_q <= sel_id;
      st_q  <= ST_RUN;
    end else begin
      pc_q  <= pc_d;
      st_q  <= st_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.prog_sel = sel_q;
  assign bus.done     = (st_q == ST_HALTED);
  assign bus.fault    = (st_q == ST_FAULT);

endmodule
